// File: rtl/hdng_err_gen.sv
// Heading-error producer: two-stage modular diff/saturate pipeline, move FSM, settle and watchdog.
// Optional deadband enabled by defining HDNG_ERR_DEADBAND_EN.
module hdng_err_gen #(
    parameter int unsigned SETTLE_THRESH = 16,
    parameter int unsigned SETTLE_CNT    = 8,
    parameter int unsigned TIMEOUT       = 4096,
    parameter int unsigned DEADBAND      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] heading,
    input  logic        hdng_vld,
    input  logic [11:0] dsrd_hdng,
    input  logic        go,
    input  logic        stop,
    output logic [9:0]  error_sat,
    output logic        err_vld,
    output logic        moving,
    output logic        settled,
    output logic        hdng_fault
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] TimeoutW  = WdW'(TIMEOUT);
    localparam logic [7:0]     SettleW   = 8'(SETTLE_CNT);
    localparam logic [10:0]    ThreshW   = 11'(SETTLE_THRESH);
    localparam logic [10:0]    DeadbandW = 11'(DEADBAND);

    typedef enum logic [1:0] {StIdle, StMoving, StFault} state_e;

    state_e           state_q;
    logic             s1_vld_q;
    logic [11:0]      diff_q;
    logic [11:0]      dsrd_q;
    logic [7:0]       settle_cnt_q;
    logic [WdW-1:0]   wd_cnt_q;

    logic signed [11:0] diff_s;
    logic [9:0]         sat_err;
    logic [9:0]         final_err;
    logic [10:0]        sat_mag;
    logic [10:0]        final_mag;
    logic               on_hdng;
    logic               dsrd_chg;

    // Stage 1: modular difference; 12-bit wrap yields the shortest-path error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            diff_q   <= 12'd0;
        end else begin
            s1_vld_q <= hdng_vld;
            if (hdng_vld) begin
                diff_q <= heading - dsrd_hdng;
            end
        end
    end

    assign diff_s = diff_q;

    always_comb begin
        sat_err = diff_s[9:0];
        if (diff_s > 12'sd511) begin
            sat_err = 10'h1FF;
        end else if (diff_s < -12'sd512) begin
            sat_err = 10'h200;
        end
    end

    // 11-bit magnitude so that -512 does not overflow.
    assign sat_mag = sat_err[9] ? (11'd0 - {1'b1, sat_err}) : {1'b0, sat_err};

`ifdef HDNG_ERR_DEADBAND_EN
    always_comb begin
        final_err = sat_err;
        final_mag = sat_mag;
        if (sat_mag <= DeadbandW) begin
            final_err = 10'd0;
            final_mag = 11'd0;
        end
    end
`else
    logic unused_deadband;
    assign unused_deadband = ^DeadbandW;
    assign final_err       = sat_err;
    assign final_mag       = sat_mag;
`endif

    assign on_hdng  = final_mag < ThreshW;
    assign dsrd_chg = dsrd_hdng != dsrd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            error_sat    <= 10'd0;
            err_vld      <= 1'b0;
            moving       <= 1'b0;
            settled      <= 1'b0;
            hdng_fault   <= 1'b0;
            dsrd_q       <= 12'd0;
            settle_cnt_q <= 8'd0;
            wd_cnt_q     <= '0;
        end else begin
            // Stage 2: register the saturated error.
            err_vld <= s1_vld_q;
            if (s1_vld_q) begin
                error_sat <= final_err;
            end
            dsrd_q  <= dsrd_hdng;
            settled <= 1'b0;

            if (state_q != StMoving || dsrd_chg) begin
                settle_cnt_q <= 8'd0;
            end else if (s1_vld_q) begin
                if (!on_hdng) begin
                    settle_cnt_q <= 8'd0;
                end else if (settle_cnt_q != SettleW) begin
                    settle_cnt_q <= settle_cnt_q + 8'd1;
                    settled      <= (settle_cnt_q + 8'd1) == SettleW;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (go && !stop) begin
                        state_q  <= StMoving;
                        moving   <= 1'b1;
                        wd_cnt_q <= '0;
                    end
                end
                StMoving: begin
                    if (stop) begin
                        state_q <= StIdle;
                        moving  <= 1'b0;
                    end else if (hdng_vld) begin
                        wd_cnt_q <= '0;
                    end else if (wd_cnt_q == TimeoutW) begin
                        state_q    <= StFault;
                        moving     <= 1'b0;
                        hdng_fault <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                StFault: begin
                    if (stop) begin
                        state_q    <= StIdle;
                        hdng_fault <= 1'b0;
                    end else if (go) begin
                        state_q    <= StMoving;
                        moving     <= 1'b1;
                        hdng_fault <= 1'b0;
                        wd_cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    moving  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdng_err_gen.sv
// Self-checking bench for hdng_err_gen against an arithmetic reference model.
module tb_hdng_err_gen;

    logic        clk;
    logic        rst;
    logic [11:0] heading;
    logic        hdng_vld;
    logic [11:0] dsrd_hdng;
    logic        go;
    logic        stop;
    logic [9:0]  error_sat;
    logic        err_vld;
    logic        moving;
    logic        settled;
    logic        hdng_fault;

    int vectors;
    int miscompares;

    hdng_err_gen dut (
        .clk        (clk),
        .rst        (rst),
        .heading    (heading),
        .hdng_vld   (hdng_vld),
        .dsrd_hdng  (dsrd_hdng),
        .go         (go),
        .stop       (stop),
        .error_sat  (error_sat),
        .err_vld    (err_vld),
        .moving     (moving),
        .settled    (settled),
        .hdng_fault (hdng_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shortest-path angle error, clamped to 10 bits, optional deadband.
    function automatic logic [9:0] ref_err(input int h, input int d);
        int e;
        e = (h - d) % 4096;
        if (e < 0) e += 4096;
        if (e >= 2048) e -= 4096;
        if (e > 511) e = 511;
        if (e < -512) e = -512;
`ifdef HDNG_ERR_DEADBAND_EN
        if (e <= 4 && e >= -4) e = 0;
`endif
        return 10'(e);
    endfunction

    task automatic test_reset();
        rst = 1'b1; heading = 12'd0; hdng_vld = 1'b0; dsrd_hdng = 12'd0; go = 1'b0; stop = 1'b0;
        tick(); tick();
        vectors += 5;
        if (error_sat !== 10'd0) begin miscompares++; $display("FAIL reset_error_sat: got %h expected 000", error_sat); end
        if (err_vld !== 1'b0) begin miscompares++; $display("FAIL reset_err_vld: got %b expected 0", err_vld); end
        if (moving !== 1'b0) begin miscompares++; $display("FAIL reset_moving: got %b expected 0", moving); end
        if (settled !== 1'b0) begin miscompares++; $display("FAIL reset_settled: got %b expected 0", settled); end
        if (hdng_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b expected 0", hdng_fault); end
        rst = 1'b0;
        tick();
        // Sample in flight when reset hits must vanish.
        heading = 12'h123; hdng_vld = 1'b1;
        tick();
        hdng_vld = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors += 2;
            if (err_vld !== 1'b0) begin miscompares++; $display("FAIL reset_flush_vld: got %b expected 0", err_vld); end
            if (error_sat !== 10'd0) begin miscompares++; $display("FAIL reset_flush_err: got %h expected 000", error_sat); end
            tick();
        end
    endtask

    task automatic test_directed();
        logic [11:0] th [5] = '{12'h100, 12'h7FF, 12'h000, 12'h010, 12'h103};
        logic [11:0] td [5] = '{12'h0F0, 12'h000, 12'h400, 12'hFF0, 12'h100};
        logic [9:0]  te [5];
        te[0] = 10'h010; te[1] = 10'h1FF; te[2] = 10'h200; te[3] = 10'h020;
`ifdef HDNG_ERR_DEADBAND_EN
        te[4] = 10'h000;
`else
        te[4] = 10'h003;
`endif
        for (int i = 0; i < 5; i++) begin
            heading = th[i]; dsrd_hdng = td[i]; hdng_vld = 1'b1;
            tick();
            hdng_vld = 1'b0;
            vectors++;
            if (err_vld !== 1'b0) begin miscompares++; $display("FAIL directed_early_vld[%0d]: got %b expected 0", i, err_vld); end
            tick();
            vectors += 2;
            if (err_vld !== 1'b1) begin miscompares++; $display("FAIL directed_vld[%0d]: got %b expected 1", i, err_vld); end
            if (error_sat !== te[i]) begin miscompares++; $display("FAIL directed_err[%0d]: got %h expected %h", i, error_sat, te[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic       vq [$];
        logic [9:0] eq [$];
        logic [9:0] last_e = 10'd0;
        logic       have_last = 1'b0;
        logic       v;
        logic [9:0] e;
        hdng_vld = 1'b0;
        tick(); tick();
        for (int i = 0; i < 302; i++) begin
            if (vq.size() == 2) begin
                v = vq.pop_front();
                e = eq.pop_front();
                vectors += 3;
                if (err_vld !== v) begin miscompares++; $display("FAIL b2b_vld[%0d]: got %b expected %b", i, err_vld, v); end
                if (v) begin
                    last_e = e; have_last = 1'b1;
                end
                if (have_last && error_sat !== last_e) begin
                    miscompares++; $display("FAIL b2b_err[%0d]: got %h expected %h", i, error_sat, last_e);
                end
                if (settled !== 1'b0) begin miscompares++; $display("FAIL b2b_settled[%0d]: got %b expected 0", i, settled); end
            end
            hdng_vld  = (i < 300) && ($urandom_range(0, 3) != 0);
            heading   = 12'($urandom);
            dsrd_hdng = ($urandom_range(0, 1) == 1) ? 12'($urandom)
                                                   : 12'(heading - 12'($urandom_range(0, 40)) + 12'd20);
            vq.push_back(hdng_vld);
            eq.push_back(ref_err(int'(heading), int'(dsrd_hdng)));
            tick();
        end
        hdng_vld = 1'b0;
    endtask

    task automatic test_go_stop();
        go = 1'b1; stop = 1'b1;
        tick();
        go = 1'b0; stop = 1'b0;
        vectors++;
        if (moving !== 1'b0) begin miscompares++; $display("FAIL gostop_idle: got %b expected 0", moving); end
        go = 1'b1;
        tick();
        go = 1'b0;
        vectors++;
        if (moving !== 1'b1) begin miscompares++; $display("FAIL go_moving: got %b expected 1", moving); end
        go = 1'b1; stop = 1'b1;
        tick();
        go = 1'b0; stop = 1'b0;
        vectors++;
        if (moving !== 1'b0) begin miscompares++; $display("FAIL gostop_moving: got %b expected 0", moving); end
    endtask

    task automatic test_settle();
        int cnt = 0;
        int pulses_exp = 0;
        int pulses_got = 0;
        int ev;
        int ab;
        int off;
        logic exp_pulse;
        logic [11:0] new_d;
        dsrd_hdng = 12'h100; hdng_vld = 1'b0;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 58; i++) begin
            if (i < 18) begin
                off = (i == 9) ? 16 : 5;
            end else begin
                off = int'($urandom_range(0, 40)) - 20;
                if ($urandom_range(0, 5) == 0) begin
                    new_d = 12'($urandom);
                    if (new_d != dsrd_hdng) cnt = 0;
                    dsrd_hdng = new_d;
                end
            end
            heading  = 12'(int'(dsrd_hdng) + off);
            hdng_vld = 1'b1;
            ev = int'($signed(ref_err(int'(heading), int'(dsrd_hdng))));
            ab = (ev < 0) ? -ev : ev;
            exp_pulse = 1'b0;
            if (ab < 16) begin
                if (cnt < 8) begin
                    cnt++;
                    exp_pulse = (cnt == 8);
                end
            end else begin
                cnt = 0;
            end
            if (exp_pulse) pulses_exp++;
            tick();
            hdng_vld = 1'b0;
            vectors++;
            if (settled !== 1'b0) begin miscompares++; $display("FAIL settle_gap[%0d]: got %b expected 0", i, settled); end
            tick();
            vectors += 2;
            if (settled === 1'b1) pulses_got++;
            if (err_vld !== 1'b1) begin miscompares++; $display("FAIL settle_vld[%0d]: got %b expected 1", i, err_vld); end
            if (settled !== exp_pulse) begin
                miscompares++; $display("FAIL settle_pulse[%0d]: got %b expected %b", i, settled, exp_pulse);
            end
            if (i == 17) begin
                vectors++;
                if (pulses_got !== 2) begin miscompares++; $display("FAIL settle_count_directed: got %0d expected 2", pulses_got); end
            end
        end
        vectors++;
        if (pulses_got !== pulses_exp) begin
            miscompares++; $display("FAIL settle_count_total: got %0d expected %0d", pulses_got, pulses_exp);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_watchdog();
        hdng_vld = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (4096) tick();
        vectors += 2;
        if (hdng_fault !== 1'b0) begin miscompares++; $display("FAIL wd_early_fault: got %b expected 0", hdng_fault); end
        if (moving !== 1'b1) begin miscompares++; $display("FAIL wd_early_moving: got %b expected 1", moving); end
        tick();
        vectors += 2;
        if (hdng_fault !== 1'b1) begin miscompares++; $display("FAIL wd_fault: got %b expected 1", hdng_fault); end
        if (moving !== 1'b0) begin miscompares++; $display("FAIL wd_fault_moving: got %b expected 0", moving); end
        go = 1'b1;
        tick();
        go = 1'b0;
        vectors += 2;
        if (hdng_fault !== 1'b0) begin miscompares++; $display("FAIL wd_go_clear: got %b expected 0", hdng_fault); end
        if (moving !== 1'b1) begin miscompares++; $display("FAIL wd_go_moving: got %b expected 1", moving); end
        // Sample arriving exactly in the expiry cycle keeps the move alive.
        repeat (4096) tick();
        hdng_vld = 1'b1;
        tick();
        hdng_vld = 1'b0;
        vectors += 2;
        if (hdng_fault !== 1'b0) begin miscompares++; $display("FAIL wd_rescue_fault: got %b expected 0", hdng_fault); end
        if (moving !== 1'b1) begin miscompares++; $display("FAIL wd_rescue_moving: got %b expected 1", moving); end
        repeat (4097) tick();
        vectors++;
        if (hdng_fault !== 1'b1) begin miscompares++; $display("FAIL wd_refault: got %b expected 1", hdng_fault); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        vectors += 2;
        if (hdng_fault !== 1'b0) begin miscompares++; $display("FAIL wd_stop_clear: got %b expected 0", hdng_fault); end
        if (moving !== 1'b0) begin miscompares++; $display("FAIL wd_stop_moving: got %b expected 0", moving); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_go_stop();
        test_settle();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hdng_err_gen.md
# hdng_err_gen

Heading-error producer for the PID path. Turns raw gyro-integrated heading samples into the saturated 10-bit error word and single-cycle valid strobe consumed by the P/I/D term blocks. It also generates the `moving` qualifier that gates the integrator, with settle detection and a heading-sample watchdog. Sits between the inertial interface and the PID term blocks.

## Interface
- `SETTLE_THRESH`, 16: |error_sat| strictly below this counts as on-heading.
- `SETTLE_CNT`, 8: consecutive on-heading samples required to flag settled (1..255).
- `TIMEOUT`, 4096: clocks without `hdng_vld` while moving before a fault (≥4).
- `DEADBAND`, 4: deadband half-width, used only with the configuration macro.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `heading` in 12: signed actual heading, modulo-4096 angle.
- `hdng_vld` in 1: one-cycle strobe, `heading` valid.
- `dsrd_hdng` in 12: signed desired heading, modulo-4096.
- `go` in 1: start-move pulse.
- `stop` in 1: abort/end-move pulse.
- `error_sat` out 10: signed saturated error, −512..511.
- `err_vld` out 1: one-cycle strobe, `error_sat` updated.
- `moving` out 1: high while in MOVING.
- `settled` out 1: one-cycle pulse on reaching settle count.
- `hdng_fault` out 1: sticky watchdog fault.

## Operation
- Stage 1 (on `hdng_vld`): `diff = heading − dsrd_hdng`, 12-bit modular, interpreted as signed. Both operands are sampled in the same cycle. Wrap gives the shortest-path error: heading 0x010, desired 0xFF0 → +0x020.
- Stage 2: saturate `diff` to 10 bits. Values >511 become 0x1FF; values <−512 become 0x200. Register the result to `error_sat` and pulse `err_vld`.
- `error_sat` holds its value between strobes. Error generation runs in every FSM state; consumers qualify with `moving`.
- FSM states: IDLE, MOVING, FAULT.
  - IDLE → MOVING on `go`.
  - MOVING → IDLE on `stop`.
  - MOVING → FAULT on watchdog expiry.
  - FAULT → MOVING on `go`, which clears `hdng_fault`.
  - FAULT → IDLE on `stop`, which also clears `hdng_fault`.
  - `go` and `stop` in the same cycle: `stop` wins.
- `moving` = (state == MOVING), registered.
- Watchdog:
  - Counter clears on every `hdng_vld` and on entry to MOVING.
  - It increments each MOVING clock without `hdng_vld`.
  - Reaching `TIMEOUT` sets `hdng_fault` and enters FAULT.
- Settle counter:
  - Active only in MOVING. Increments on each stage-2 result with |error_sat| < `SETTLE_THRESH`, and clears on any result at or above the threshold.
  - On reaching `SETTLE_CNT`, `settled` pulses once. The counter then saturates, so no further pulses occur until it is cleared.
  - Cleared on leaving MOVING and on any change of `dsrd_hdng`.

## Timing
- Reset values: `error_sat` = 0, `err_vld` = 0, `moving` = 0, `settled` = 0, `hdng_fault` = 0, state IDLE, all counters 0.
- Latency: `hdng_vld` in cycle N → `err_vld`/`error_sat` in cycle N+2. Fully pipelined, so back-to-back `hdng_vld` gives back-to-back `err_vld`.
- `settled` asserts in the same cycle as the qualifying `err_vld`.
- `go` in cycle N → `moving` high in N+1. `stop` in N → `moving` low in N+1.
- Watchdog expiry at count `TIMEOUT` → `hdng_fault`/`moving` change in the next cycle.
- `hdng_vld` arriving in the expiry cycle prevents the fault.
- Reset mid-pipeline discards in-flight samples; no `err_vld` follows reset.

## Configuration
- `HDNG_ERR_DEADBAND_EN` defined: after saturation, |error| ≤ `DEADBAND` is forced to 0 before registering. Settle compare uses the forced value.
- Undefined: no deadband; the saturated error passes through unchanged.

## Test plan
- Reset, then `hdng_vld` with heading 0x100, dsrd 0x0F0 → `err_vld` 2 cycles later, `error_sat` = 0x010.
- heading 0x7FF, dsrd 0x000 → `error_sat` = 0x1FF. Then heading 0x000, dsrd 0x400 (diff 0xC00 = −1024) → `error_sat` = 0x200.
- Wrap: heading 0x010, dsrd 0xFF0 → `error_sat` = 0x020.
- `go`, then 8 samples of error 5 → `settled` pulses once, on the 8th `err_vld`. A 9th sample produces no pulse. A sample with error 16 followed by 8 more small samples → exactly one new pulse.
- `go`, then no `hdng_vld` for 4096 clocks → `hdng_fault` = 1, `moving` = 0. Next `go` → fault clears, `moving` = 1.
- `go` and `stop` in the same cycle from IDLE → `moving` stays 0. With the macro: error 3 → `error_sat` = 0; without it → 3.
